// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD countdown counter.
// Imported by the digit slice and the counter top level.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  function automatic logic bcd_digit_ok(
    input logic [BCD_W-1:0] d
  );
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit: parallel load, decrement with 0 -> 9 wrap.
// borrow_out flags a zero digit so the next digit up can borrow.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      if (q == '0)
        q <= BCD_MAX;
      else
        q <= q - 4'd1;
    end
  end

  assign borrow_out = (q == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// N-digit loadable BCD countdown counter with expiry pulse
// and optional periodic reload.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int N           = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [4*N-1:0]   load_value,
  input  logic             enable,
  output logic [4*N-1:0]   Q,
  output logic             running,
  output logic             zero,
  output logic             done,
  output logic             load_err
);

  localparam logic [4*N-1:0] ONE = {{(4*N-1){1'b0}}, 1'b1};

  state_t           state;
  logic [4*N-1:0]   reload_q;
  logic [4*N-1:0]   digit_src;
  logic [N-1:0]     digit_ok;
  logic [N-1:0]     borrow;
  logic [N-1:0]     dec;
  logic             all_ok;
  logic             valid_load;
  logic             bad_load;
  logic             is_one;
  logic             expire;
  logic             reload;
  logic             digit_load;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_dig
      assign digit_ok[i] =
        bcd_digit_ok(load_value[4*i +: 4]);

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .load       (digit_load),
        .load_val   (digit_src[4*i +: 4]),
        .dec        (dec[i]),
        .q          (Q[4*i +: 4]),
        .borrow_out (borrow[i])
      );

      if (i < N-1) begin : g_chain
        assign dec[i+1] = dec[i] & borrow[i];
      end
    end
  endgenerate

  assign all_ok     = &digit_ok;
  assign valid_load = load & all_ok;
  assign bad_load   = load & ~all_ok;

  assign running = (state == RUN);
  assign zero    = (Q == '0);
  assign is_one  = (Q == ONE);

  // A rejected load does not block the tick.
  assign expire = running & enable
                & is_one & ~valid_load;
  assign reload = expire & AUTO_RELOAD;

  assign digit_load = valid_load | reload;
  assign digit_src  = valid_load ? load_value
                                 : reload_q;

  assign dec[0] = running & enable
                & ~valid_load & ~reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      reload_q <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= bad_load;
      if (valid_load) begin
        reload_q <= load_value;
        if (load_value == '0)
          state <= IDLE;
        else
          state <= RUN;
      end else if (expire) begin
        done <= 1'b1;
        if (!AUTO_RELOAD)
          state <= EXPIRED;
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter, N = 3.
// Instance u0 runs one-shot, u1 runs with auto reload.
module tb_bcd_down_counter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;

  logic            load0 = 1'b0;
  logic [4*N-1:0]  lv0 = '0;
  logic            en0 = 1'b0;
  logic [4*N-1:0]  q0;
  logic            run0, zero0, done0, err0;

  logic            load1 = 1'b0;
  logic [4*N-1:0]  lv1 = '0;
  logic            en1 = 1'b0;
  logic [4*N-1:0]  q1;
  logic            run1, zero1, done1, err1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.N(N), .AUTO_RELOAD(1'b0)) u0 (
    .clk        (clk),
    .reset      (reset),
    .load       (load0),
    .load_value (lv0),
    .enable     (en0),
    .Q          (q0),
    .running    (run0),
    .zero       (zero0),
    .done       (done0),
    .load_err   (err0)
  );

  bcd_down_counter #(.N(N), .AUTO_RELOAD(1'b1)) u1 (
    .clk        (clk),
    .reset      (reset),
    .load       (load1),
    .load_value (lv1),
    .enable     (en1),
    .Q          (q1),
    .running    (run1),
    .zero       (zero1),
    .done       (done1),
    .load_err   (err1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < N; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(
    input logic [4*N-1:0] v
  );
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < N; d++)
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_q",    32'(q0),    32'h000);
    check("rst_run",  32'(run0),  32'd0);
    check("rst_zero", 32'(zero0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err",  32'(err0),  32'd0);
    reset = 1'b0;

    // 1: countdown and expiry
    load0 = 1'b1; lv0 = 12'h005;
    step;
    load0 = 1'b0;
    check("t1_load_q",   32'(q0),   32'h005);
    check("t1_load_run", 32'(run0), 32'd1);
    en0 = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      step;
      check("t1_q",    32'(q0),    32'(to_bcd(k)));
      check("t1_done", 32'(done0), 32'(k == 0));
    end
    check("t1_exp_run",  32'(run0),  32'd0);
    check("t1_exp_zero", 32'(zero0), 32'd1);
    repeat (3) begin
      step;
      check("t1_hold_q",    32'(q0),    32'h000);
      check("t1_hold_done", 32'(done0), 32'd0);
    end
    en0 = 1'b0;

    // 2: borrow across digits, zero load
    load0 = 1'b1; lv0 = 12'h100;
    step;
    load0 = 1'b0; en0 = 1'b1;
    check("t2_load100", 32'(q0), 32'h100);
    step;
    check("t2_099", 32'(q0), 32'h099);
    step;
    check("t2_098", 32'(q0), 32'h098);
    en0 = 1'b0; load0 = 1'b1; lv0 = 12'h010;
    step;
    load0 = 1'b0; en0 = 1'b1;
    check("t2_load010", 32'(q0), 32'h010);
    step;
    check("t2_009", 32'(q0), 32'h009);
    en0 = 1'b0; load0 = 1'b1; lv0 = 12'h000;
    step;
    load0 = 1'b0;
    check("t2_z_q",    32'(q0),    32'h000);
    check("t2_z_run",  32'(run0),  32'd0);
    check("t2_z_zero", 32'(zero0), 32'd1);
    check("t2_z_done", 32'(done0), 32'd0);

    // 3: invalid load with enable honoured
    load0 = 1'b1; lv0 = 12'h123;
    step;
    load0 = 1'b0; en0 = 1'b1;
    check("t3_load", 32'(q0), 32'h123);
    step;
    check("t3_122", 32'(q0), 32'h122);
    step;
    check("t3_121", 32'(q0), 32'h121);
    load0 = 1'b1; lv0 = 12'h1A3;
    step;
    load0 = 1'b0; en0 = 1'b0;
    check("t3_bad_q",   32'(q0),   32'h120);
    check("t3_bad_err", 32'(err0), 32'd1);
    check("t3_bad_run", 32'(run0), 32'd1);
    step;
    check("t3_err_clr", 32'(err0), 32'd0);
    check("t3_hold",    32'(q0),   32'h120);

    // 5: load beats enable, async reset
    load0 = 1'b1; lv0 = 12'h057;
    step;
    check("t5_057", 32'(q0), 32'h057);
    lv0 = 12'h200; en0 = 1'b1;
    step;
    load0 = 1'b0;
    check("t5_200", 32'(q0), 32'h200);
    step;
    check("t5_199", 32'(q0), 32'h199);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_q",    32'(q0),   32'h000);
    check("t5_rst_run",  32'(run0), 32'd0);
    check("t5_rst_done", 32'(done0), 32'd0);
    #2 reset = 1'b0;
    step;
    check("t5_post_q",   32'(q0),   32'h000);
    check("t5_post_run", 32'(run0), 32'd0);
    en0 = 1'b0;

    // 4: auto reload on u1
    load1 = 1'b1; lv1 = 12'h003; en1 = 1'b1;
    step;
    load1 = 1'b0;
    check("t4_load", 32'(q1), 32'h003);
    for (int k = 0; k < 6; k++) begin
      step;
      check("t4_q",    32'(q1),    32'(to_bcd(2 - (k % 3)
                                   + ((k % 3) == 2 ? 3 : 0))));
      check("t4_done", 32'(done1), 32'((k % 3) == 2));
      check("t4_run",  32'(run1),  32'd1);
    end
    en1 = 1'b0;

    // 6: full-range sweep
    load0 = 1'b1; lv0 = 12'h999; en0 = 1'b1;
    step;
    load0 = 1'b0;
    check("t6_load", 32'(q0), 32'h999);
    for (int k = 1; k <= 999; k++) begin
      step;
      check("t6_q",    32'(q0),    32'(to_bcd(999 - k)));
      check("t6_dig",  32'(digits_ok(q0)), 32'd1);
      check("t6_done", 32'(done0), 32'(k == 999));
    end
    en0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- N-digit loadable BCD countdown counter; the decrementing counterpart of the team's cascaded BCD up-counter.
- Software or an upstream FSM loads a BCD value, then the counter decrements once per `enable` tick.
- It signals expiry with a one-cycle `done` pulse and can optionally reload itself to run as a periodic BCD timer.
- Sits between the tick generator and the display/timeout logic.

Parameters:
- N, 3, number of BCD digits (N >= 1).
- AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop at zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  load `load_value` this cycle.
- load_value  in  4*N  packed BCD; digit 0 in bits [3:0], digit i in bits [4i+3:4i].
- enable  in  1  count tick; decrement by one when in RUN.
- Q  out  4*N  current count, packed BCD, same digit order as `load_value`.
- running  out  1  high while in RUN.
- zero  out  1  high when Q == 0 (all digits 0).
- done  out  1  one-cycle pulse on expiry.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, any time, including mid-count):
  - Q = 0, reload register = 0, state = IDLE.
  - running = 0, done = 0, load_err = 0, zero = 1.
- States: IDLE, RUN, EXPIRED. `running` = (state == RUN). Outputs Q, done and load_err are registered.
- Priority in any state: reset > load > enable.
- Load validation: a load is valid only if every digit of `load_value` is <= 9.
- Invalid load:
  - Q, reload register and state are unchanged.
  - load_err = 1 the next cycle.
  - Any enable in that same cycle is still honoured as if there were no load.
- Valid load:
  - Q and reload register take `load_value` next cycle; enable in the same cycle is ignored.
  - Next state = RUN if the value is nonzero.
  - Next state = IDLE if the value is zero; no done pulse is generated.
- IDLE and EXPIRED: enable is ignored and Q holds. EXPIRED leaves only on load or reset.
- RUN with enable = 0: Q holds.
- RUN with enable = 1 and Q > 1: Q decrements by exactly 1 in BCD.
  - Digit i decrements when enable & (digits 0..i-1 are all 0).
  - A digit at 0 that decrements wraps to 9 (borrow). Example: 100 -> 099.
- RUN with enable = 1 and Q == 1 (expiry):
  - AUTO_RELOAD = 0: Q -> 0, state -> EXPIRED, done = 1 in the same cycle Q first reads 0.
  - AUTO_RELOAD = 1: Q -> reload register, state stays RUN, done = 1 for that cycle. Q never shows 0 in this mode.
- Cadence: done lasts exactly one cycle per expiry, even if enable is held high continuously.
- Latency:
  - Q updates 1 cycle after the enable/load edge.
  - done/load_err are coincident with the Q update.
- Reload of zero cannot occur, because RUN is only entered with a nonzero value.
- All digits of Q stay within 0..9 at all times.

Decomposition:
- Shared package `bcd_pkg`:
  - state encoding localparams (IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2);
  - BCD digit width constant (4);
  - BCD_MAX = 4'd9.
- Sub-module `bcd_down_digit`: one 4-bit digit with parallel load, decrement-with-wrap, and a `borrow_out` flag (digit == 0).
- The top level instantiates N digits in a generate loop and chains the decrement enables:
  - dec[0] = tick;
  - dec[i+1] = dec[i] & borrow_out[i].
- The FSM, load validation and the done/load_err registers live in the top level.

Test Plan (N = 3):
1. Countdown and expiry (AUTO_RELOAD = 0): reset, load 005, 5 enable pulses -> Q goes 004, 003, 002, 001, 000; done is high exactly one cycle, coincident with Q = 000; then state is EXPIRED, and 3 further enables leave Q = 000 with no done.
2. Borrow across digits: load 100, enable -> Q = 099; enable -> Q = 098. Load 010, enable -> Q = 009. Load 000 -> state IDLE, zero = 1, no done.
3. Invalid load: load 123, 2 enables (Q = 121), then load 1A3 with enable high -> load_err pulses once, Q = 120 (the enable is honoured), state remains RUN.
4. AUTO_RELOAD = 1: load 003 with enable held high -> Q sequence 002, 001, 003, 002, 001, 003; done pulses on each 001 -> 003 transition, every 3 cycles; running stays 1.
5. Priority and reset: during RUN at Q = 057, assert load = 1 (load_value = 200) together with enable -> Q = 200 with no decrement. Mid-count, assert reset asynchronously between clock edges -> Q = 000, running = 0, done = 0 immediately; the first enable after release does nothing.
6. Full-range sweep: load 999 with enable held high -> 999 consecutive decrements with every digit <= 9 throughout; done appears only on the 999th tick.
